// File: rtl/modulo_counter_pkg.sv
// Shared definitions for the modulo counter.
//   DefaultWidth : default bit width of the count, bound and load data
//   action_e     : per-edge action once reset has been ruled out
//   decode_action: resolves load-over-count priority and wrap detection
package modulo_counter_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        ActLoad,
        ActWrap,
        ActIncr
    } action_e;

    // Load beats counting. The bound test is ">=" rather than "==", so a value
    // above the bound (from a load or a shrinking max) wraps on the next edge.
    function automatic action_e decode_action(input logic set_value, input logic at_or_above);
        if (set_value) begin
            return ActLoad;
        end else if (at_or_above) begin
            return ActWrap;
        end else begin
            return ActIncr;
        end
    endfunction

endpackage

// File: rtl/modulo_counter_next.sv
// Next-state logic for the modulo counter (load / wrap / increment).
// Reset is not handled here; the register stage applies it with top priority.
// Ports:
//   i_value        current registered count
//   i_max          terminal count
//   i_value_to_set load data
//   i_set_value    load strobe
//   o_next_value   count for the next edge
//   o_next_ovf     overflow flag for the next edge (set only on a wrap)
module modulo_counter_next
    import modulo_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] i_max,
    input  logic [WIDTH-1:0] i_value_to_set,
    input  logic             i_set_value,
    output logic [WIDTH-1:0] o_next_value,
    output logic             o_next_ovf
);

    action_e          w_action;
    logic             w_at_or_above;
    logic [WIDTH-1:0] w_incr;

    assign w_at_or_above = (i_value >= i_max);
    // WIDTH-bit increment; carry-out is dropped, the >= test wraps first anyway.
    assign w_incr        = i_value + WIDTH'(1);
    assign w_action      = decode_action(i_set_value, w_at_or_above);

    always_comb begin
        o_next_value = i_value;
        o_next_ovf   = 1'b0;
        unique case (w_action)
            ActLoad: begin
                o_next_value = i_value_to_set;
                o_next_ovf   = 1'b0;
            end
            ActWrap: begin
                o_next_value = '0;
                o_next_ovf   = 1'b1;
            end
            ActIncr: begin
                o_next_value = w_incr;
                o_next_ovf   = 1'b0;
            end
            default: begin
                o_next_value = i_value;
                o_next_ovf   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/modulo_counter.sv
// Free-running modulo-(max+1) up-counter with synchronous load and a
// registered one-cycle wrap pulse. Used as a divider / bit-period timer.
// Ports:
//   clk           clock, all state on posedge
//   rst           synchronous active-high reset (overrides load and count)
//   max           terminal count; sequence is 0..max
//   value_to_set  load data (any value accepted, even above max)
//   set_value     load strobe, level sampled each edge
//   value         registered current count
//   overflow      registered wrap pulse, high while value reads 0 after a wrap
module modulo_counter
    import modulo_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] value_to_set,
    input  logic             set_value,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    logic [WIDTH-1:0] r_value;
    logic             r_overflow;
    logic [WIDTH-1:0] w_next_value;
    logic             w_next_ovf;

    modulo_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .i_value       (r_value),
        .i_max         (max),
        .i_value_to_set(value_to_set),
        .i_set_value   (set_value),
        .o_next_value  (w_next_value),
        .o_next_ovf    (w_next_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_value    <= w_next_value;
            r_overflow <= w_next_ovf;
        end
    end

    assign value    = r_value;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_modulo_counter.sv
module tb_modulo_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] max;
    logic [7:0] value_to_set;
    logic       set_value;
    logic [7:0] value;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    modulo_counter #(
        .WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .max         (max),
        .value_to_set(value_to_set),
        .set_value   (set_value),
        .value       (value),
        .overflow    (overflow)
    );

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_v, input logic exp_o);
        n_vec++;
        assert ({value, overflow} === {exp_v, exp_o})
        else begin
            n_err++;
            $error("FAIL %s: value=%0d overflow=%0b, expected value=%0d overflow=%0b",
                   tag, value, overflow, exp_v, exp_o);
        end
    endtask

    initial begin
        logic [7:0] m_v;
        logic       m_o;

        rst = 1'b1; max = 8'd9; value_to_set = 8'd0; set_value = 1'b0;

        // 1: reset then a full 0..9 period
        step(); step();
        check("reset", 8'd0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("count", 8'(i), 1'b0);
        end
        step();
        check("wrap10", 8'd0, 1'b1);

        // 2: load 5 mid-count, wrap 5 edges after the load
        set_value = 1'b1; value_to_set = 8'd5;
        step();
        check("load5", 8'd5, 1'b0);
        set_value = 1'b0;
        for (int i = 6; i <= 9; i++) begin
            step();
            check("after_load", 8'(i), 1'b0);
        end
        step();
        check("load_wrap", 8'd0, 1'b1);
        step();
        check("post_wrap", 8'd1, 1'b0);

        // 3: out-of-range load wraps on next edge
        set_value = 1'b1; value_to_set = 8'd200;
        step();
        check("load200", 8'd200, 1'b0);
        set_value = 1'b0;
        step();
        check("oor_wrap", 8'd0, 1'b1);
        step();
        check("oor_next", 8'd1, 1'b0);

        // 4a: max=0 -> divide by one
        max = 8'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("max0", 8'd0, 1'b1);
        end

        // 4b: max=255 full-range, 256-cycle period
        max = 8'd255;
        m_v = 8'd0;
        for (int i = 0; i < 256; i++) begin
            step();
            m_v = (m_v == 8'd255) ? 8'd0 : m_v + 8'd1;
            check("full_range", m_v, (i == 255) ? 1'b1 : 1'b0);
        end
        step();
        check("full_after", 8'd1, 1'b0);

        // shrinking max wraps on the next edge
        max = 8'd9;
        for (int i = 2; i <= 5; i++) step();
        check("pre_shrink", 8'd5, 1'b0);
        max = 8'd3;
        step();
        check("shrink_wrap", 8'd0, 1'b1);

        // 5: load beats a pending wrap; reset beats both
        max = 8'd9;
        for (int i = 0; i < 9; i++) step();
        check("at_bound", 8'd9, 1'b0);
        set_value = 1'b1; value_to_set = 8'd3;
        step();
        check("load_on_wrap", 8'd3, 1'b0);
        set_value = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("at_bound2", 8'd9, 1'b0);
        rst = 1'b1; set_value = 1'b1; value_to_set = 8'd7;
        step();
        check("rst_on_wrap", 8'd0, 1'b0);
        rst = 1'b0; set_value = 1'b0;
        step();
        check("rst_release", 8'd1, 1'b0);

        // set_value held high: value follows load data, overflow stays 0
        set_value = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value_to_set = 8'(40 + i * 11);
            step();
            check("held_load", 8'(40 + i * 11), 1'b0);
        end
        set_value = 1'b0;

        // 6: random stimulus against a reference model
        m_v = value;
        m_o = overflow;
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 63) == 0);
            set_value    = ($urandom_range(0, 15) == 0);
            max          = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            value_to_set = 8'($urandom);
            if (rst) begin
                m_v = 8'd0; m_o = 1'b0;
            end else if (set_value) begin
                m_v = value_to_set; m_o = 1'b0;
            end else if (m_v >= max) begin
                m_v = 8'd0; m_o = 1'b1;
            end else begin
                m_v = m_v + 8'd1; m_o = 1'b0;
            end
            step();
            check("random", m_v, m_o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
